// File: rtl/btn_debounce_if.sv
// Button/key-event bundle for btn_debounce: sample strobe, raw buttons, debounced
// outputs and the single-entry key-event handshake (master = debouncer side).
interface btn_debounce_if #(
    parameter int N_BTN = 5
);
    logic             tick10ms;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             key_valid;
    logic [2:0]       key_code;
    logic             key_ovf;
    logic             key_ack;

    modport master (
        input  tick10ms, btn_raw, key_ack,
        output btn_level, btn_press, btn_release, key_valid, key_code, key_ovf
    );

    modport slave (
        output tick10ms, btn_raw, key_ack,
        input  btn_level, btn_press, btn_release, key_valid, key_code, key_ovf
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-button tick-sampled debouncer with press/release pulses and a one-deep key-event
// register. Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_debounce #(
    parameter int N_BTN        = 5,
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_TICKS = 10
) (
    input logic            mclk,
    input logic            clr,
    btn_debounce_if.master bus
);
    typedef enum logic [1:0] {
        REL        = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_e;

    localparam logic [7:0] ST8 = 8'(STABLE_TICKS);

    if (N_BTN < 1 || N_BTN > 8 || STABLE_TICKS < 1 || STABLE_TICKS > 255 ||
        REPEAT_DELAY < 1 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("btn_debounce: parameter out of legal range");
    end

    logic [N_BTN-1:0] sync1_q, sync2_q;
    state_e           state_q [N_BTN];
    state_e           state_d [N_BTN];
    logic [7:0]       cnt_q   [N_BTN];
    logic [7:0]       cnt_d   [N_BTN];
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rel_q, rel_d;
    logic             key_valid_q, key_valid_d;
    logic [2:0]       key_code_q, key_code_d;
    logic             key_ovf_q, key_ovf_d;
    logic [2:0]       key_low_s;
    logic             key_multi_s;
    logic             ack_eff_s;
`ifdef BTN_REPEAT_EN
    localparam logic [7:0] RD8 = 8'(REPEAT_DELAY);
    localparam logic [7:0] RT8 = 8'(REPEAT_TICKS);
    logic [7:0]       rpt_q [N_BTN];
    logic [7:0]       rpt_d [N_BTN];
    logic [N_BTN-1:0] rep_q, rep_d;
`endif

    // Per-button debounce FSM next state; every transition is gated by the tick strobe.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            press_d[i] = 1'b0;
            rel_d[i]   = 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_d[i]   = rpt_q[i];
            rep_d[i]   = rep_q[i];
`endif
            if (bus.tick10ms) begin
                case (state_q[i])
                    REL: begin
                        if (!sync2_q[i]) begin
                            cnt_d[i] = 8'd0;
                        end else if (ST8 == 8'd1) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = 8'd0;
                            press_d[i] = 1'b1;
                        end else begin
                            state_d[i] = PRESS_WAIT;
                            cnt_d[i]   = 8'd1;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_q[i]) begin
                            state_d[i] = REL;
                            cnt_d[i]   = 8'd0;
                        end else if (cnt_q[i] + 8'd1 == ST8) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = 8'd0;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    HELD: begin
                        if (sync2_q[i]) begin
                            cnt_d[i] = 8'd0;
                        end else if (ST8 == 8'd1) begin
                            state_d[i] = REL;
                            cnt_d[i]   = 8'd0;
                            rel_d[i]   = 1'b1;
                        end else begin
                            state_d[i] = REL_WAIT;
                            cnt_d[i]   = 8'd1;
                        end
                    end
                    REL_WAIT: begin
                        if (sync2_q[i]) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = 8'd0;
                        end else if (cnt_q[i] + 8'd1 == ST8) begin
                            state_d[i] = REL;
                            cnt_d[i]   = 8'd0;
                            rel_d[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    default: begin
                        state_d[i] = REL;
                        cnt_d[i]   = 8'd0;
                    end
                endcase
`ifdef BTN_REPEAT_EN
                // Repeat count advances on every held tick (including a REL_WAIT abort) and freezes while release is pending.
                if (state_d[i] == REL || state_d[i] == PRESS_WAIT) begin
                    rpt_d[i] = 8'd0;
                    rep_d[i] = 1'b0;
                end else if (sync2_q[i] && (state_q[i] == HELD || state_q[i] == REL_WAIT)) begin
                    if (!rep_q[i] && rpt_q[i] + 8'd1 == RD8) begin
                        rpt_d[i]   = 8'd0;
                        rep_d[i]   = 1'b1;
                        press_d[i] = 1'b1;
                    end else if (rep_q[i] && rpt_q[i] + 8'd1 == RT8) begin
                        rpt_d[i]   = 8'd0;
                        press_d[i] = 1'b1;
                    end else begin
                        rpt_d[i] = rpt_q[i] + 8'd1;
                    end
                end else begin
                    rpt_d[i] = rpt_q[i];
                end
`endif
            end else begin
                state_d[i] = state_q[i];
            end
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == REL_WAIT);
        end
    end

    // Key-event register fed by the visible btn_press pulses; lowest index wins.
    always_comb begin
        key_low_s   = 3'd0;
        key_multi_s = (press_q & (press_q - N_BTN'(1))) != '0;
        ack_eff_s   = bus.key_ack & key_valid_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_ovf_d   = key_ovf_q;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                key_low_s = 3'(i);
            end else begin
                key_low_s = key_low_s;
            end
        end
        if (press_q != '0) begin
            if (key_valid_q && !bus.key_ack) begin
                key_ovf_d = 1'b1;
            end else begin
                key_valid_d = 1'b1;
                key_code_d  = key_low_s;
                key_ovf_d   = key_multi_s | (key_ovf_q & ~ack_eff_s);
            end
        end else if (ack_eff_s) begin
            key_valid_d = 1'b0;
            key_ovf_d   = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end
    end

    // State, synchronizer and output registers; clr clears everything immediately.
    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 3'd0;
            key_ovf_q   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= 8'd0;
            end
`ifdef BTN_REPEAT_EN
            rep_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rpt_q[i] <= 8'd0;
            end
`endif
        end else begin
            sync1_q     <= bus.btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ovf_q   <= key_ovf_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef BTN_REPEAT_EN
            rep_q <= rep_d;
            for (int i = 0; i < N_BTN; i++) begin
                rpt_q[i] <= rpt_d[i];
            end
`endif
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_ovf     = key_ovf_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Randomized bench for btn_debounce: a run-length reference model predicts every output
// each cycle; directed tasks add explicit scenario checks.
module tb_btn_debounce;
    localparam int NB = 5;
    localparam int ST = 2;
    localparam int RD = 3;
    localparam int RT = 2;
    localparam int TP = 8;
    localparam int VW = 3 * NB + 5;

    logic mclk = 1'b0;
    logic clr;
    always #5 mclk = ~mclk;

    btn_debounce_if #(.N_BTN(NB)) bus ();
    btn_debounce #(.N_BTN(NB), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_TICKS(RT))
        dut (.mclk(mclk), .clr(clr), .bus(bus));

    int checks = 0;
    int errors = 0;
    int tcnt   = 0;
    bit auto_tick = 1'b1;

    // Reference model: a level flips after ST consecutive disagreeing tick samples.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl, lvl_d, pr_d, rl_d;
    int            m_run [NB];
    int            run_d [NB];
    int            m_held [NB];
    int            held_d [NB];
    logic          m_vld, vld_d, m_ovf, ovf_d;
    logic [2:0]    m_code, code_d, low;
    int            np;

    always_comb begin
        lvl_d = m_lvl; pr_d = '0; rl_d = '0; run_d = m_run; held_d = m_held;
        vld_d = m_vld; code_d = m_code; ovf_d = m_ovf; np = 0; low = 3'd0;
        if (bus.tick10ms) begin
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] !== m_lvl[i]) begin
                    run_d[i] = m_run[i] + 1;
                    if (run_d[i] >= ST) begin
                        lvl_d[i] = m_s2[i]; run_d[i] = 0; held_d[i] = 0;
                        pr_d[i] = m_s2[i]; rl_d[i] = ~m_s2[i];
                    end
                end else begin
                    run_d[i] = 0;
`ifdef BTN_REPEAT_EN
                    if (m_lvl[i]) begin
                        held_d[i] = m_held[i] + 1;
                        if (held_d[i] == RD || (held_d[i] > RD && (held_d[i] - RD) % RT == 0))
                            pr_d[i] = 1'b1;
                    end
`endif
                end
            end
        end
        for (int i = NB - 1; i >= 0; i--) if (m_pr[i]) begin np++; low = 3'(i); end
        if (np > 0) begin
            if (m_vld && !bus.key_ack) ovf_d = 1'b1;
            else begin
                vld_d = 1'b1; code_d = low;
                ovf_d = (np > 1) || (m_ovf && !(bus.key_ack && m_vld));
            end
        end else if (bus.key_ack && m_vld) begin
            vld_d = 1'b0; ovf_d = 1'b0;
        end
    end

    always @(posedge mclk or posedge clr) begin
        if (clr) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_pr <= '0; m_rl <= '0;
            m_vld <= 1'b0; m_code <= 3'd0; m_ovf <= 1'b0;
            for (int i = 0; i < NB; i++) begin m_run[i] <= 0; m_held[i] <= 0; end
        end else begin
            m_s1 <= bus.btn_raw; m_s2 <= m_s1; m_lvl <= lvl_d; m_pr <= pr_d; m_rl <= rl_d;
            m_vld <= vld_d; m_code <= code_d; m_ovf <= ovf_d;
            m_run <= run_d; m_held <= held_d;
        end
    end

    logic [VW-1:0] exp_v, obs_v;
    assign exp_v = {m_lvl, m_pr, m_rl, m_vld, m_code, m_ovf};
    assign obs_v = {bus.btn_level, bus.btn_press, bus.btn_release,
                    bus.key_valid, bus.key_code, bus.key_ovf};

    task automatic adv();
        @(negedge mclk);
        if (auto_tick) begin
            tcnt = (tcnt + 1) % TP;
            bus.tick10ms = (tcnt == 0);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.btn_raw = '0; bus.key_ack = 1'b0; bus.tick10ms = 1'b0;
        repeat (3) adv();
        checks++;
        if (obs_v !== '0) begin errors++; $display("FAIL reset: got %h want 0", obs_v); end
        clr = 1'b0;
    endtask

    task automatic test_press();
        int pulses = 0, qt = 0;
        bit prev_tick = 1'b0;
        bus.btn_raw = 5'b00100;
        for (int c = 0; c < 3 * TP + 3; c++) begin
            adv();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL press cyc %0d: got %h want %h", c, obs_v, exp_v); end
            if (bus.btn_press[2]) begin
                pulses++;
                checks++;
                if (qt != 2 || !prev_tick) begin errors++; $display("FAIL press_latency: qualifying ticks %0d prev_tick %0d want 2 1", qt, prev_tick); end
            end
            prev_tick = bus.tick10ms;
            if (bus.tick10ms && m_s2[2]) qt++;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL press_pulses: got %0d want 1", pulses); end
        adv();
        checks++;
        if (bus.key_code !== 3'd2 || bus.key_valid !== 1'b1) begin errors++; $display("FAIL press_key: got code %0d valid %b want 2 1", bus.key_code, bus.key_valid); end
        bus.key_ack = 1'b1; adv(); bus.key_ack = 1'b0;
        bus.btn_raw = '0;
        for (int c = 0; c < 4 * TP; c++) begin
            adv();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL release cyc %0d: got %h want %h", c, obs_v, exp_v); end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int c = 0; c < 6 * TP; c++) begin
            adv();
            bus.btn_raw[0] = (tcnt >= 1 && tcnt <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL bounce cyc %0d: got %h want %h", c, obs_v, exp_v); end
            if (bus.btn_press[0]) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.btn_level[0] !== 1'b0) begin errors++; $display("FAIL bounce_result: presses %0d level %b want 0 0", pulses, bus.btn_level[0]); end
        bus.btn_raw = '0;
    endtask

    task automatic test_simul();
        bus.btn_raw = 5'b01010;
        for (int c = 0; c < 3 * TP + 3; c++) begin
            adv();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL simul cyc %0d: got %h want %h", c, obs_v, exp_v); end
        end
        checks++;
        if (bus.key_code !== 3'd1 || bus.key_ovf !== 1'b1 || bus.key_valid !== 1'b1) begin
            errors++; $display("FAIL simul_key: got code %0d ovf %b valid %b want 1 1 1", bus.key_code, bus.key_ovf, bus.key_valid);
        end
        bus.key_ack = 1'b1; adv(); bus.key_ack = 1'b0;
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key_ovf !== 1'b0) begin errors++; $display("FAIL simul_ack: got valid %b ovf %b want 0 0", bus.key_valid, bus.key_ovf); end
        bus.btn_raw = '0;
        for (int c = 0; c < 4 * TP; c++) adv();
    endtask

    task automatic test_clr_mid();
        int nt = 0, guard = 0;
        bit seen = 1'b0;
        bus.btn_raw = 5'b10000;
        while (m_run[4] != 1 && guard < 4 * TP) begin adv(); guard++; end
        checks++;
        if (m_run[4] != 1) begin errors++; $display("FAIL clr_setup: timed out reaching PRESS_WAIT"); end
        #2 clr = 1'b1;
        #1;
        checks++;
        if (obs_v !== '0) begin errors++; $display("FAIL clr_async: got %h want 0", obs_v); end
        do adv(); while (tcnt != 1);
        clr = 1'b0;
        for (int c = 0; c < 5 * TP && !seen; c++) begin
            adv();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL clr cyc %0d: got %h want %h", c, obs_v, exp_v); end
            if (bus.btn_press[4]) seen = 1'b1;
            else if (bus.tick10ms) nt++;
        end
        checks++;
        if (!seen || nt != 2) begin errors++; $display("FAIL clr_requalify: seen %b ticks %0d want 1 2", seen, nt); end
        bus.btn_raw = '0;
        for (int c = 0; c < 4 * TP; c++) adv();
        bus.key_ack = 1'b1; adv(); bus.key_ack = 1'b0;
    endtask

    task automatic test_ack_press();
        int guard = 0;
        bus.btn_raw = 5'b00001;
        while (!m_vld && guard < 5 * TP) begin adv(); guard++; end
        bus.btn_raw = '0;
        while (m_lvl[0] && guard < 10 * TP) begin adv(); guard++; end
        bus.btn_raw = 5'b10000;
        while (!m_pr[4] && guard < 15 * TP) begin adv(); guard++; end
        checks++;
        if (!m_pr[4] || !m_vld) begin errors++; $display("FAIL ack_press_setup: timed out, guard %0d", guard); end
        bus.key_ack = 1'b1; adv(); bus.key_ack = 1'b0;
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 3'd4 || bus.key_ovf !== 1'b0) begin
            errors++; $display("FAIL ack_press: got valid %b code %0d ovf %b want 1 4 0", bus.key_valid, bus.key_code, bus.key_ovf);
        end
        bus.btn_raw = '0;
        for (int c = 0; c < 4 * TP; c++) adv();
        bus.key_ack = 1'b1; adv(); bus.key_ack = 1'b0;
    endtask

`ifdef BTN_REPEAT_EN
    task automatic test_repeat();
        int ticks = 0, first = -1, n = 0, rels = 0;
        int offs [4];
        int want [4] = '{0, 3, 5, 7};
        bus.btn_raw = 5'b00001;
        for (int c = 0; c < 12 * TP; c++) begin
            adv();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL repeat cyc %0d: got %h want %h", c, obs_v, exp_v); end
            if (bus.btn_press[0]) begin
                if (first < 0) first = ticks;
                if (n < 4) offs[n] = ticks - first;
                n++;
            end
            if (bus.tick10ms) ticks++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (n <= k || offs[k] != want[k]) begin errors++; $display("FAIL repeat_offset %0d: got %0d want %0d (pulses %0d)", k, (n > k) ? offs[k] : -1, want[k], n); end
        end
        bus.btn_raw = '0;
        for (int c = 0; c < 4 * TP; c++) begin adv(); if (bus.btn_release[0]) rels++; end
        checks++;
        if (rels != 1) begin errors++; $display("FAIL repeat_release: got %0d want 1", rels); end
        bus.key_ack = 1'b1; adv(); bus.key_ack = 1'b0;
    endtask
`endif

    task automatic test_random();
        auto_tick = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            adv();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random cyc %0d: got %h want %h", c, obs_v, exp_v); end
            bus.tick10ms = ($urandom_range(0, 3) == 0);
            bus.key_ack  = ($urandom_range(0, 7) == 0);
            clr          = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 15) == 0) bus.btn_raw[i] = ~bus.btn_raw[i];
        end
        clr = 1'b0; bus.key_ack = 1'b0; bus.tick10ms = 1'b0;
        auto_tick = 1'b1;
    endtask

    initial begin
        clr = 1'b1; bus.btn_raw = '0; bus.key_ack = 1'b0; bus.tick10ms = 1'b0;
        test_reset();
        test_press();
        test_bounce();
        test_simul();
        test_clr_mid();
        test_ack_press();
`ifdef BTN_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter N_BTN, default 5, number of button inputs; legal range 1..8.
REQ-002 Parameter STABLE_TICKS, default 2, consecutive tick10ms samples required to accept a level change; legal range 1..255.
REQ-003 Parameter REPEAT_DELAY, default 50, ticks held before the first auto-repeat; used only with BTN_REPEAT_EN.
REQ-004 Parameter REPEAT_TICKS, default 10, ticks between auto-repeats; used only with BTN_REPEAT_EN.
REQ-005 mclk  input  1  single system clock, 100 MHz, all logic on rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-high.
REQ-007 tick10ms  input  1  one-mclk-cycle sample strobe from the clock divider, every 1,000,000 cycles.
REQ-008 btn_raw  input  N_BTN  asynchronous active-high button levels.
REQ-009 btn_level  output  N_BTN  debounced stable levels.
REQ-010 btn_press  output  N_BTN  one-cycle pulse per accepted press (and per repeat).
REQ-011 btn_release  output  N_BTN  one-cycle pulse per accepted release.
REQ-012 key_valid  output  1  pending key event, held until acknowledged.
REQ-013 key_code  output  3  index of the pending key event.
REQ-014 key_ovf  output  1  sticky flag: a press was dropped while key_valid was pending.
REQ-015 key_ack  input  1  consumer acknowledge, one cycle.

Function
REQ-016 Each btn_raw bit SHALL pass through a two-flop synchronizer; FSMs see only the second-stage value (sync).
REQ-017 Each button SHALL have an independent FSM: REL, PRESS_WAIT, HELD, REL_WAIT; plus an 8-bit tick counter.
REQ-018 FSM and counter SHALL advance only on cycles with tick10ms=1; all other cycles hold state.
REQ-019 REL: sync=1 on tick -> PRESS_WAIT, cnt=1; if STABLE_TICKS=1 go directly to HELD.
REQ-020 PRESS_WAIT: sync=1 on tick -> cnt+1; on cnt reaching STABLE_TICKS -> HELD; sync=0 on tick -> REL, cnt=0.
REQ-021 HELD/REL_WAIT SHALL mirror REQ-019/020 with sync polarity inverted; abort returns to HELD.
REQ-022 btn_level SHALL be 1 exactly in HELD and REL_WAIT, updated on the same edge as the transition.
REQ-023 btn_press/btn_release SHALL assert for exactly the one mclk cycle following the accepting tick edge; never wider.
REQ-024 Worst-case press latency SHALL be 2 mclk + STABLE_TICKS ticks + 1 mclk.
REQ-025 On any btn_press, key_code SHALL load the lowest pressed index in that cycle and key_valid SHALL set; higher simultaneous indices are dropped and set key_ovf.
REQ-026 Press while key_valid=1 and key_ack=0: key_code unchanged, key_ovf set.
REQ-027 key_ack with no press: key_valid and key_ovf clear next edge; key_ack with key_valid=0: no effect.
REQ-028 key_ack and press same cycle: new code loaded, key_valid stays 1, key_ovf cleared.

Reset
REQ-029 clr=1 SHALL immediately force all FSMs to REL, counters and synchronizers to 0, and all outputs to 0.
REQ-030 Reset mid-debounce SHALL discard progress; a held button after clr release re-qualifies from REL with a full STABLE_TICKS count.

Configuration
REQ-031 Macro BTN_REPEAT_EN defined: in HELD, a per-button repeat counter counts ticks; pulse btn_press at REPEAT_DELAY ticks after entry, then every REPEAT_TICKS; counter clears on leaving HELD; REL_WAIT pauses it.
REQ-032 Macro BTN_REPEAT_EN undefined: no repeat counter logic; exactly one btn_press per accepted press.

Verification
REQ-033 btn_raw[2]=1 steady, tick every 8 cycles (bench override), STABLE_TICKS=2 -> btn_press[2] one cycle after 2nd qualifying tick, key_code=2, key_valid=1.
REQ-034 btn_raw[0] bounces 1/0 between ticks ending at 0 at each tick -> no btn_press, btn_level[0]=0.
REQ-035 btn_raw[1] and [3] rise together -> key_code=1, key_ovf=1; key_ack -> key_valid=0, key_ovf=0.
REQ-036 clr pulsed while btn_raw[4]=1 in PRESS_WAIT -> all outputs 0 asynchronously; press accepted only after 2 further ticks.
REQ-037 BTN_REPEAT_EN, REPEAT_DELAY=3, REPEAT_TICKS=2, hold btn 0 -> btn_press at qualifying tick, +3, +5, +7 ticks; release -> one btn_release.
REQ-038 key_ack coincident with new press of btn 4 -> key_valid stays 1, key_code=4.
